// File: rtl/sat_addsub_pipe_pkg.sv
// Shared definitions for the saturating add/subtract pipeline.
//   ADDSUB_OP_ADD / ADDSUB_OP_SUB : encoding of the 'sub' operation select
//   smax_of(w) / smin_of(w)       : signed max/min of a w-bit value (w <= 64),
//                                   returned zero-extended to 64 bits
package sat_addsub_pipe_pkg;

    localparam logic ADDSUB_OP_ADD = 1'b0;
    localparam logic ADDSUB_OP_SUB = 1'b1;

    function automatic logic [63:0] smax_of(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] smin_of(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/sat_addsub_pipe_addsub_slice.sv
// addsub_slice: combinational W-bit adder a + b + cin.
// Ports:
//   a, b   in  W  addends (b already inverted by the caller for subtraction)
//   cin    in  1  carry in
//   sum    out W  a + b + cin mod 2^W
//   cout   out 1  carry out of the MSB
//   c_msb  out 1  carry into the MSB (overflow = c_msb ^ cout)
module addsub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    // Low W-1 bits are added with one spare bit so the carry into the MSB
    // is visible; the MSB is then added separately.
    logic [W-1:0] low_ext;
    logic [1:0]   top;

    always_comb begin
        low_ext = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + {{(W-1){1'b0}}, cin};
        top     = {1'b0, a[W-1]} + {1'b0, b[W-1]} + {1'b0, low_ext[W-1]};
    end

    assign sum   = {top[0], low_ext[W-2:0]};
    assign cout  = top[1];
    assign c_msb = low_ext[W-1];

endmodule

// File: rtl/sat_addsub_pipe.sv
// sat_addsub_pipe: pipelined two's-complement add/subtract with per-op
// saturate/wrap, signed overflow flag and sticky overflow status.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       operand beat handshake (a, b, sub, sat_en)
//   out_valid/out_ready     result beat handshake (sum, ovfl)
//   ovfl_sticky             set by any accepted result with ovfl=1
//   clr_sticky              synchronous clear of ovfl_sticky (set wins)
// PIPE=1 computes the full result in one stage; PIPE=2 splits the carry
// chain at WIDTH/2 with a register between the halves.
module sat_addsub_pipe
    import sat_addsub_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int PIPE  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             ovfl,
    output logic             ovfl_sticky,
    input  logic             clr_sticky
);

    localparam logic [63:0]      SMAX_W = smax_of(WIDTH);
    localparam logic [63:0]      SMIN_W = smin_of(WIDTH);
    localparam logic [WIDTH-1:0] SMAX   = SMAX_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SMIN   = SMIN_W[WIDTH-1:0];

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             ovfl_q;
    logic             sticky_q;

    // Next-state of the output stage, produced by the selected pipeline shape.
    logic             out_valid_d;
    logic [WIDTH-1:0] sum_d;
    logic             ovfl_d;

    logic             ready_out;
    logic [WIDTH-1:0] b_eff;

    assign ready_out = ~out_valid_q | out_ready;
    assign b_eff     = (sub == ADDSUB_OP_SUB) ? ~b : b;

    if (PIPE == 2) begin : g_pipe2
        localparam int H = WIDTH / 2;

        logic         s1_valid_q;
        logic [H-1:0] s1_lo_q;
        logic         s1_c_q;
        logic [H-1:0] s1_a_hi_q;
        logic [H-1:0] s1_b_hi_q;
        logic         s1_sat_q;
        logic         s1_ready;

        logic [H-1:0] lo_sum;
        logic         lo_cout;
        logic         unused_lo_cmsb;
        logic [H-1:0] hi_sum;
        logic         hi_cout;
        logic         hi_cmsb;

        addsub_slice #(.W(H)) u_lo (
            .a     (a[H-1:0]),
            .b     (b_eff[H-1:0]),
            .cin   (sub),
            .sum   (lo_sum),
            .cout  (lo_cout),
            .c_msb (unused_lo_cmsb)
        );

        assign s1_ready = ~s1_valid_q | ready_out;
        assign in_ready = s1_ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid_q <= 1'b0;
                s1_lo_q    <= '0;
                s1_c_q     <= 1'b0;
                s1_a_hi_q  <= '0;
                s1_b_hi_q  <= '0;
                s1_sat_q   <= 1'b0;
            end else if (s1_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_lo_q   <= lo_sum;
                    s1_c_q    <= lo_cout;
                    s1_a_hi_q <= a[WIDTH-1:H];
                    s1_b_hi_q <= b_eff[WIDTH-1:H];
                    s1_sat_q  <= sat_en;
                end
            end
        end

        addsub_slice #(.W(H)) u_hi (
            .a     (s1_a_hi_q),
            .b     (s1_b_hi_q),
            .cin   (s1_c_q),
            .sum   (hi_sum),
            .cout  (hi_cout),
            .c_msb (hi_cmsb)
        );

        // Overflow direction follows the sign of a: only a non-negative a
        // can overflow upwards, only a negative a downwards.
        assign ovfl_d      = hi_cmsb ^ hi_cout;
        assign sum_d       = (s1_sat_q & ovfl_d) ? (s1_a_hi_q[H-1] ? SMIN : SMAX)
                                                 : {hi_sum, s1_lo_q};
        assign out_valid_d = s1_valid_q;
    end else begin : g_pipe1
        logic [WIDTH-1:0] raw;
        logic             cout;
        logic             cmsb;

        addsub_slice #(.W(WIDTH)) u_full (
            .a     (a),
            .b     (b_eff),
            .cin   (sub),
            .sum   (raw),
            .cout  (cout),
            .c_msb (cmsb)
        );

        assign in_ready    = ready_out;
        assign ovfl_d      = cmsb ^ cout;
        assign sum_d       = (sat_en & ovfl_d) ? (a[WIDTH-1] ? SMIN : SMAX) : raw;
        assign out_valid_d = in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            ovfl_q      <= 1'b0;
        end else if (ready_out) begin
            out_valid_q <= out_valid_d;
            if (out_valid_d) begin
                sum_q  <= sum_d;
                ovfl_q <= ovfl_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (out_valid_q & out_ready & ovfl_q) begin
            sticky_q <= 1'b1;
        end else if (clr_sticky) begin
            sticky_q <= 1'b0;
        end
    end

    assign out_valid   = out_valid_q;
    assign sum         = sum_q;
    assign ovfl        = ovfl_q;
    assign ovfl_sticky = sticky_q;

endmodule

// File: tb/tb_sat_addsub_pipe.sv
// Directed bench for sat_addsub_pipe: 16-bit/2-stage instance for the
// directed vectors, plus 8-bit 1-stage and 2-stage instances exercised with
// random traffic against an integer model.
module tb_sat_addsub_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 16-bit, PIPE=2
    logic        in_valid16, in_ready16, sub16, sat16, out_valid16, out_ready16;
    logic        ovfl16, sticky16, clr16;
    logic [15:0] a16, b16, sum16;

    // 8-bit instances share stimulus; sel8 picks the active one
    logic       sel8, v8, rdy8, sub8, sat8;
    logic [7:0] a8, b8;
    logic       p1_in_ready, p1_out_valid, p1_ovfl, p1_sticky;
    logic       p2_in_ready, p2_out_valid, p2_ovfl, p2_sticky;
    logic [7:0] p1_sum, p2_sum;
    logic       m_in_ready, m_out_valid, m_ovfl;
    logic [7:0] m_sum;

    int n_cmp = 0;
    int n_err = 0;

    sat_addsub_pipe #(.WIDTH(16), .PIPE(2)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .sub(sub16), .sat_en(sat16),
        .out_valid(out_valid16), .out_ready(out_ready16), .sum(sum16), .ovfl(ovfl16),
        .ovfl_sticky(sticky16), .clr_sticky(clr16)
    );

    sat_addsub_pipe #(.WIDTH(8), .PIPE(1)) u_dut8p1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8 & ~sel8), .in_ready(p1_in_ready),
        .a(a8), .b(b8), .sub(sub8), .sat_en(sat8),
        .out_valid(p1_out_valid), .out_ready(rdy8 | sel8), .sum(p1_sum), .ovfl(p1_ovfl),
        .ovfl_sticky(p1_sticky), .clr_sticky(1'b0)
    );

    sat_addsub_pipe #(.WIDTH(8), .PIPE(2)) u_dut8p2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8 & sel8), .in_ready(p2_in_ready),
        .a(a8), .b(b8), .sub(sub8), .sat_en(sat8),
        .out_valid(p2_out_valid), .out_ready(rdy8 | ~sel8), .sum(p2_sum), .ovfl(p2_ovfl),
        .ovfl_sticky(p2_sticky), .clr_sticky(1'b0)
    );

    assign m_in_ready  = sel8 ? p2_in_ready  : p1_in_ready;
    assign m_out_valid = sel8 ? p2_out_valid : p1_out_valid;
    assign m_sum       = sel8 ? p2_sum       : p1_sum;
    assign m_ovfl      = sel8 ? p2_ovfl      : p1_ovfl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {ovfl, sum} from signed integer arithmetic
    function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic s, input logic sat);
        int         ia, ib, r;
        logic       ov;
        logic [7:0] res;
        ia  = int'($signed(a));
        ib  = int'($signed(b));
        r   = s ? ia - ib : ia + ib;
        ov  = (r > 127) || (r < -128);
        res = r[7:0];
        if (ov && sat) res = (r > 127) ? 8'h7F : 8'h80;
        return {ov, res};
    endfunction

    task automatic put16(input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic sat);
        @(negedge clk);
        in_valid16 = 1'b1;
        a16 = a; b16 = b; sub16 = s; sat16 = sat;
    endtask

    task automatic idle16();
        @(negedge clk);
        in_valid16 = 1'b0;
    endtask

    // Issue one beat with out_ready=1 and check it appears exactly 2 cycles later.
    task automatic one16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic sat, input logic [15:0] es, input logic eo,
                         input string tag);
        put16(a, b, s, sat);
        #1 chk({tag, "_in_ready"}, in_ready16, 1);
        idle16();
        chk({tag, "_lat1_valid"}, out_valid16, 0);
        idle16();
        chk({tag, "_valid"}, out_valid16, 1);
        chk({tag, "_sum"}, sum16, es);
        chk({tag, "_ovfl"}, ovfl16, eo);
    endtask

    task automatic run_rand(input logic which, input int nbeats, input int vpct,
                            input int rpct, input int exp_cycles, input string tag);
        logic [8:0] q[$];
        logic [8:0] e;
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        sel8 = which;
        while (got < nbeats && cyc < nbeats * 20) begin
            @(negedge clk);
            cyc++;
            v8   = (sent < nbeats) && ($urandom_range(99) < vpct);
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            sub8 = 1'($urandom);
            sat8 = 1'($urandom);
            rdy8 = ($urandom_range(99) < rpct);
            #1;
            if (m_out_valid && rdy8) begin
                if (q.size() == 0) begin
                    chk({tag, "_unexpected_out"}, 1, 0);
                end else begin
                    e = q.pop_front();
                    chk({tag, "_sum"}, m_sum, e[7:0]);
                    chk({tag, "_ovfl"}, m_ovfl, e[8]);
                end
                got++;
            end
            if (v8 && m_in_ready) begin
                q.push_back(model8(a8, b8, sub8, sat8));
                sent++;
            end
        end
        chk({tag, "_count"}, got, nbeats);
        if (exp_cycles > 0) chk({tag, "_cycles"}, cyc, exp_cycles);
        @(negedge clk);
        v8 = 1'b0; rdy8 = 1'b1;
    endtask

    initial begin
        int sent, got, cyc, seen;

        rst_n = 1'b0;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0; sat16 = 1'b0;
        out_ready16 = 1'b1; clr16 = 1'b0;
        sel8 = 1'b0; v8 = 1'b0; rdy8 = 1'b1; a8 = '0; b8 = '0; sub8 = 1'b0; sat8 = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid16, 0);
        chk("rst_sum", sum16, 0);
        chk("rst_ovfl", ovfl16, 0);
        chk("rst_sticky", sticky16, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready16, 1);

        // saturation / wrap vectors
        one16(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, "add_pos_sat");
        one16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b1, "add_pos_wrap");
        one16(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, "sub_neg_sat");
        one16(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, "sub_plain");
        one16(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, "add_neg_wrap");
        one16(16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b1, "add_neg_sat");
        one16(16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 16'h7FFF, 1'b1, "sub_pos_sat");
        one16(16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, "add_plain");
        one16(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, "add_mid_carry");
        one16(16'h0100, 16'h0001, 1'b1, 1'b0, 16'h00FF, 1'b0, "sub_mid_borrow");

        // sticky behaviour
        @(negedge clk);
        chk("sticky_set", sticky16, 1);
        clr16 = 1'b1;
        @(negedge clk);
        clr16 = 1'b0;
        chk("sticky_clr", sticky16, 0);

        put16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        idle16();
        idle16();
        chk("sticky_both_valid", out_valid16, 1);
        clr16 = 1'b1;
        @(negedge clk);
        clr16 = 1'b0;
        chk("sticky_set_wins", sticky16, 1);
        clr16 = 1'b1;
        @(negedge clk);
        clr16 = 1'b0;
        chk("sticky_clr2", sticky16, 0);

        out_ready16 = 1'b0;
        put16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        idle16();
        idle16();
        idle16();
        chk("stall_valid", out_valid16, 1);
        chk("stall_sum_held", sum16, 16'h8000);
        chk("stall_sticky", sticky16, 0);
        chk("stall_in_ready", in_ready16, 1);
        out_ready16 = 1'b1;
        @(negedge clk);
        chk("stall_release_sticky", sticky16, 1);
        chk("stall_release_valid", out_valid16, 0);
        clr16 = 1'b1;
        @(negedge clk);
        clr16 = 1'b0;

        // back-to-back 6 beats with 5 stalled cycles
        sent = 0; got = 0; cyc = 0;
        while (got < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            out_ready16 = (cyc > 5);
            in_valid16  = (sent < 6);
            a16 = 16'(sent * 256); b16 = 16'(16 + sent); sub16 = 1'b0; sat16 = 1'b1;
            #1;
            if (cyc == 3) begin
                chk("b2b_in_ready_stall", in_ready16, 0);
                chk("b2b_accepted_before_stall", sent, 2);
            end
            if (out_valid16 && out_ready16) begin
                chk("b2b_sum", sum16, 16'(got * 256 + 16 + got));
                got++;
            end
            if (in_valid16 && in_ready16) sent++;
        end
        chk("b2b_count", got, 6);
        chk("b2b_sent", sent, 6);
        idle16();
        #1 chk("b2b_no_dup", out_valid16, 0);

        // reset with two beats in flight
        one16(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, "pre_rst");
        @(negedge clk);
        chk("pre_rst_sticky", sticky16, 1);
        put16(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        put16(16'h4000, 16'h4000, 1'b0, 1'b0);
        idle16();
        chk("inflight_valid", out_valid16, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid16, 0);
        chk("midrst_sum", sum16, 0);
        chk("midrst_sticky", sticky16, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid16) seen++;
        end
        chk("postrst_no_stale", seen, 0);
        one16(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, "postrst_op");

        // 8-bit random vs integer model, then full-throughput streams
        run_rand(1'b0, 1500, 80, 70, 0, "w8p1_rand");
        run_rand(1'b1, 1500, 80, 70, 0, "w8p2_rand");
        run_rand(1'b0, 40, 100, 100, 41, "w8p1_tput");
        run_rand(1'b1, 40, 100, 100, 42, "w8p2_tput");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
